pipeline_control: RTL and testbench
===================================

Name: pipeline_control

Overview:
- Owns the enable and flush inputs of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Decides, every cycle, whether the pipeline advances, freezes, or takes a bubble. Causes are memory wait, instruction-fetch miss, taken branch, jump, load-use hazard and halt drain.
- Keeps a small state machine for data-memory wait and halt sequencing, plus stall, flush and timeout counters.

Parameters:
- CNT_W, 32, width of the stall_cnt and flush_cnt performance counters.
- DWAIT_MAX, 1024, number of consecutive DWAIT cycles after which mem_timeout is set.

Ports:
- CLK input 1: clock, rising edge.
- RST input 1: asynchronous, active-high reset.
- ihit input 1: instruction memory returned a valid instruction this cycle.
- dhit input 1: data memory completed the MEM-stage access this cycle.
- mem_dREN input 1: MEM stage holds a load.
- mem_dWEN input 1: MEM stage holds a store.
- mem_branch_taken input 1: resolved taken branch in the MEM stage.
- mem_halt input 1: halt instruction in the MEM stage.
- ex_jump input 1: J, JAL or JR in the EX stage.
- idex_dREN input 1: ID/EX holds a load.
- idex_rt input 5: destination of the load in ID/EX.
- ifid_rs input 5: rs field of the instruction in IF/ID.
- ifid_rt input 5: rt field of the instruction in IF/ID.
- pc_en output 1: PC register write enable.
- en_ifid, en_idex, en_exmem, en_memwb output 1 each: pipeline register enables.
- flush_ifid, flush_idex, flush_exmem, flush_memwb output 1 each: pipeline register clears, sampled at the next CLK edge.
- halt output 1: processor halted.
- mem_timeout output 1: sticky flag, data memory failed to respond within DWAIT_MAX cycles.
- stall_cnt output CNT_W: count of cycles with pc_en=0 while in RUN or DWAIT.
- flush_cnt output CNT_W: count of cycles with any flush asserted, excluding reset.

Behaviour:
- Clock and reset: single clock CLK; RST is asynchronous, active-high.
- Reset values:
  - state=RUN; stall_cnt=0; flush_cnt=0; mem_timeout=0; halt=0.
  - While RST is high: all en_*=0, all flush_*=1, pc_en=0.
  - Reset mid-operation discards DWAIT/DRAIN progress and the timeout count.
- Output decode: enables and flushes are combinational from the state register and current inputs, so a hazard has zero-cycle reaction latency. Counters and state are registered.
- Let memreq = mem_dREN | mem_dWEN.
- Let lu = idex_dREN & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt).
- States: RUN, DWAIT, DRAIN, HALTED.
- RUN → DWAIT when memreq & !dhit.
- DWAIT → RUN on dhit. If mem_halt is also high at that edge, go to DRAIN instead.
- RUN → DRAIN when mem_halt & !(memreq & !dhit).
- DRAIN → HALTED after exactly 1 cycle, so the MEM/WB instruction retires.
- HALTED is terminal until RST.
- Priority in RUN/DWAIT (highest first, first match wins):
  1. Memory wait (memreq & !dhit):
     - pc_en=0; en_ifid=en_idex=en_exmem=0.
     - en_memwb=1 with flush_memwb=1, inserting a bubble into WB.
  2. Taken branch (mem_branch_taken):
     - pc_en=1; all enables=1.
     - flush_ifid=flush_idex=flush_exmem=1.
     - Overrides both lu and !ihit.
  3. Jump (ex_jump): pc_en=1; all enables=1; flush_ifid=flush_idex=1.
  4. Load-use (lu):
     - pc_en=0; en_ifid=0.
     - en_idex=1 with flush_idex=1, giving a 1-cycle bubble.
     - en_exmem=en_memwb=1.
  5. Fetch miss (!ihit): pc_en=0; en_ifid=1 with flush_ifid=1; downstream enables=1.
  6. Default: pc_en=1; all enables=1; all flushes=0.
- DRAIN: pc_en=0; en_ifid=en_idex=en_exmem=0; en_memwb=1; flush_ifid=flush_idex=flush_exmem=1.
- HALTED: halt=1; all enables=0; all flushes=0; pc_en=0; inputs ignored.
- Timeout counter:
  - Internal, clog2(DWAIT_MAX+1) bits; increments each DWAIT cycle and clears on leaving DWAIT.
  - Reaching DWAIT_MAX sets mem_timeout, which stays set until RST.
  - The state stays in DWAIT; timeout is a flag only.
- Performance counters: both saturate at all-ones and do not wrap. Neither counts in DRAIN or HALTED.

Decomposition:
- cpu_types_pkg gains the pc_state_t enum (RUN, DWAIT, DRAIN, HALTED) and regbits_t (5-bit register index), if not already present.
- One sub-module, sat_counter (parameter W, inputs inc and clr), is instantiated for stall_cnt and flush_cnt.
- Hazard decode stays inline in pipeline_control.

Test Plan:
- Reset then idle: RST=1 → all flush_*=1, pc_en=0. Release with ihit=1 → pc_en=1, all en_*=1, stall_cnt and flush_cnt stay 0.
- Load-use: idex_dREN=1, idex_rt=8, ifid_rs=8 → one cycle with pc_en=0, en_ifid=0, flush_idex=1; stall_cnt=1. Repeat with idex_rt=0 → no stall.
- Branch beats load-use: mem_branch_taken=1 and lu=1 in the same cycle → flush_ifid/idex/exmem=1, pc_en=1; flush_cnt increments by 1.
- Memory wait: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 → DWAIT for 3 cycles with all upstream enables 0 and flush_memwb=1; back to RUN; stall_cnt=3.
- Timeout: DWAIT_MAX=4, dhit held 0 → mem_timeout=1 after the 4th DWAIT cycle and stays 1 after dhit; cleared only by RST.
- Halt: mem_halt=1, memreq=0 → DRAIN for 1 cycle (en_memwb=1), then HALTED with halt=1 and pc_en=0. Pulse RST mid-DRAIN → RUN with halt=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register indices, pipeline control FSM state
// and the packed control word decoded each cycle.
package cpu_types_pkg;
   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      RUN,
      DWAIT,
      DRAIN,
      HALTED
   } pc_state_t;

   // en/fl bit order: [3]=ifid [2]=idex [1]=exmem [0]=memwb
   typedef struct packed {
      logic       pc_en;
      logic [3:0] en;
      logic [3:0] fl;
   } ctrl_t;
endpackage

// File: rtl/pipeline_control_if.sv
// Hazard inputs and pipeline-register control outputs of the
// pipeline controller, grouped as one bundle.
interface pipeline_control_if #(
   parameter int CNT_W = 32
);
   import cpu_types_pkg::*;

   logic     ihit;
   logic     dhit;
   logic     mem_dREN;
   logic     mem_dWEN;
   logic     mem_branch_taken;
   logic     mem_halt;
   logic     ex_jump;
   logic     idex_dREN;
   regbits_t idex_rt;
   regbits_t ifid_rs;
   regbits_t ifid_rt;

   logic pc_en;
   logic en_ifid;
   logic en_idex;
   logic en_exmem;
   logic en_memwb;
   logic flush_ifid;
   logic flush_idex;
   logic flush_exmem;
   logic flush_memwb;
   logic halt;
   logic mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      input  ihit, dhit, mem_dREN, mem_dWEN,
      input  mem_branch_taken, mem_halt, ex_jump,
      input  idex_dREN, idex_rt, ifid_rs, ifid_rt,
      output pc_en, en_ifid, en_idex, en_exmem, en_memwb,
      output flush_ifid, flush_idex, flush_exmem, flush_memwb,
      output halt, mem_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      output ihit, dhit, mem_dREN, mem_dWEN,
      output mem_branch_taken, mem_halt, ex_jump,
      output idex_dREN, idex_rt, ifid_rs, ifid_rt,
      input  pc_en, en_ifid, en_idex, en_exmem, en_memwb,
      input  flush_ifid, flush_idex, flush_exmem, flush_memwb,
      input  halt, mem_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && cnt != '1)
         cnt <= cnt + W'(1);
   end
endmodule

// File: rtl/pipeline_control.sv
// Pipeline advance/freeze/bubble control: memory wait, fetch miss,
// branch, jump, load-use and halt drain, plus perf/timeout counters.
module pipeline_control
   import cpu_types_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int DWAIT_MAX = 1024
) (
   input logic                CLK,
   input logic                RST,
   pipeline_control_if.master cif
);
   localparam int TW = $clog2(DWAIT_MAX + 1);
   localparam logic [TW-1:0] TMAX = TW'(DWAIT_MAX);

   pc_state_t     state;
   logic [TW-1:0] tcnt;
   logic          tmo_q;
   logic          halt_q;
   logic          memreq;
   logic          mwait;
   logic          lu;
   logic          active;
   ctrl_t         c;

   assign memreq = cif.mem_dREN | cif.mem_dWEN;
   assign mwait  = memreq & ~cif.dhit;
   assign lu = cif.idex_dREN & (cif.idex_rt != '0) &
               ((cif.idex_rt == cif.ifid_rs) |
                (cif.idex_rt == cif.ifid_rt));

   always_comb begin
      c = '0;
      if (RST) begin
         c.fl = '1;
      end else begin
         unique case (state)
            RUN, DWAIT: begin
               if (mwait) begin
                  c.en = 4'b0001;
                  c.fl = 4'b0001;
               end else if (cif.mem_branch_taken) begin
                  c.pc_en = 1'b1;
                  c.en    = 4'b1111;
                  c.fl    = 4'b1110;
               end else if (cif.ex_jump) begin
                  c.pc_en = 1'b1;
                  c.en    = 4'b1111;
                  c.fl    = 4'b1100;
               end else if (lu) begin
                  c.en = 4'b0111;
                  c.fl = 4'b0100;
               end else if (!cif.ihit) begin
                  c.en = 4'b1111;
                  c.fl = 4'b1000;
               end else begin
                  c.pc_en = 1'b1;
                  c.en    = 4'b1111;
               end
            end
            DRAIN: begin
               // let the MEM/WB instruction retire, squash the rest
               c.en = 4'b0001;
               c.fl = 4'b1110;
            end
            default: c = '0;
         endcase
      end
   end

   assign cif.pc_en       = c.pc_en;
   assign cif.en_ifid     = c.en[3];
   assign cif.en_idex     = c.en[2];
   assign cif.en_exmem    = c.en[1];
   assign cif.en_memwb    = c.en[0];
   assign cif.flush_ifid  = c.fl[3];
   assign cif.flush_idex  = c.fl[2];
   assign cif.flush_exmem = c.fl[1];
   assign cif.flush_memwb = c.fl[0];
   assign cif.halt        = halt_q;
   assign cif.mem_timeout = tmo_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= RUN;
         tcnt   <= '0;
         tmo_q  <= 1'b0;
         halt_q <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (mwait)
                  state <= DWAIT;
               else if (cif.mem_halt)
                  state <= DRAIN;
            end
            DWAIT: begin
               if (cif.dhit) begin
                  state <= cif.mem_halt ? DRAIN : RUN;
                  tcnt  <= '0;
               end else begin
                  if (tcnt != TMAX)
                     tcnt <= tcnt + TW'(1);
                  if (tcnt >= TMAX - TW'(1))
                     tmo_q <= 1'b1;
               end
            end
            DRAIN: begin
               state  <= HALTED;
               halt_q <= 1'b1;
            end
            default: state <= HALTED;
         endcase
      end
   end

   assign active = (state == RUN) | (state == DWAIT);

   sat_counter #(.W(CNT_W)) u_stall (
      .CLK (CLK),
      .RST (RST),
      .inc (active & ~c.pc_en),
      .clr (1'b0),
      .cnt (cif.stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush (
      .CLK (CLK),
      .RST (RST),
      .inc (active & (|c.fl)),
      .clr (1'b0),
      .cnt (cif.flush_cnt)
   );
endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench: directed plan steps then random traffic, each
// cycle predicted by a rule-level model and checked at negedge.
module tb_pipeline_control;
   localparam int CW   = 6;
   localparam int DMAX = 4;
   localparam int SMAX = (1 << CW) - 1;

   logic CLK = 1'b0;
   logic RST;

   always #5 CLK = ~CLK;

   pipeline_control_if #(.CNT_W(CW)) cif ();

   pipeline_control #(
      .CNT_W     (CW),
      .DWAIT_MAX (DMAX)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .cif (cif.master)
   );

   typedef struct packed {
      logic       rst;
      logic       ihit;
      logic       dhit;
      logic       dren;
      logic       dwen;
      logic       br;
      logic       mh;
      logic       jmp;
      logic       ldr;
      logic [4:0] irt;
      logic [4:0] rs;
      logic [4:0] rt;
   } in_t;

   typedef struct packed {
      logic          pc;
      logic [3:0]    en;
      logic [3:0]    fl;
      logic          hlt;
      logic          tmo;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int   checks = 0;
   int   errors = 0;

   // model: 0 running, 1 waiting on dmem, 2 draining, 3 halted
   int mode  = 0;
   int waits = 0;
   int msc   = 0;
   int mfc   = 0;
   bit mtmo  = 1'b0;

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", n, act, exp, $time);
      end
   endtask

   function automatic exp_t predict(input in_t v);
      exp_t e;
      bit   stall_mem;
      bit   hz;
      e = '0;
      stall_mem = (v.dren | v.dwen) & ~v.dhit;
      hz = v.ldr && v.irt != 0 && (v.irt == v.rs || v.irt == v.rt);
      if (v.rst) begin
         e.fl = 4'b1111;
         return e;
      end
      e.hlt = (mode == 3);
      e.tmo = mtmo;
      e.sc  = CW'(msc);
      e.fc  = CW'(mfc);
      if (mode == 3) begin
         e.pc = 0;
      end else if (mode == 2) begin
         e.en = 4'b0001;
         e.fl = 4'b1110;
      end else if (stall_mem) begin
         e.en = 4'b0001;
         e.fl = 4'b0001;
      end else if (v.br) begin
         e.pc = 1; e.en = 4'b1111; e.fl = 4'b1110;
      end else if (v.jmp) begin
         e.pc = 1; e.en = 4'b1111; e.fl = 4'b1100;
      end else if (hz) begin
         e.en = 4'b0111; e.fl = 4'b0100;
      end else if (!v.ihit) begin
         e.en = 4'b1111; e.fl = 4'b1000;
      end else begin
         e.pc = 1; e.en = 4'b1111;
      end
      return e;
   endfunction

   task automatic advance(input in_t v, input exp_t e);
      if (v.rst) begin
         mode = 0; waits = 0; msc = 0; mfc = 0; mtmo = 0;
         return;
      end
      if (mode < 2) begin
         if (!e.pc && msc < SMAX) msc++;
         if (e.fl != 0 && mfc < SMAX) mfc++;
      end
      case (mode)
         0: begin
            if ((v.dren | v.dwen) && !v.dhit) mode = 1;
            else if (v.mh) mode = 2;
         end
         1: begin
            if (v.dhit) begin
               mode  = v.mh ? 2 : 0;
               waits = 0;
            end else begin
               waits++;
               if (waits >= DMAX) mtmo = 1;
            end
         end
         2: mode = 3;
         default: ;
      endcase
   endtask

   task automatic step(input in_t v);
      exp_t e;
      @(posedge CLK);
      #1;
      RST                  = v.rst;
      cif.ihit             = v.ihit;
      cif.dhit             = v.dhit;
      cif.mem_dREN         = v.dren;
      cif.mem_dWEN         = v.dwen;
      cif.mem_branch_taken = v.br;
      cif.mem_halt         = v.mh;
      cif.ex_jump          = v.jmp;
      cif.idex_dREN        = v.ldr;
      cif.idex_rt          = v.irt;
      cif.ifid_rs          = v.rs;
      cif.ifid_rt          = v.rt;
      e = predict(v);
      q.push_back(e);
      advance(v, e);
   endtask

   function automatic in_t idle();
      in_t v;
      v = '0;
      v.ihit = 1'b1;
      return v;
   endfunction

   function automatic in_t rsti();
      in_t v;
      v = idle();
      v.rst = 1'b1;
      return v;
   endfunction

   always @(negedge CLK) begin
      if (q.size() > 0) begin
         me = q.pop_front();
         chk("ctrl",
             int'({cif.pc_en, cif.en_ifid, cif.en_idex,
                   cif.en_exmem, cif.en_memwb, cif.flush_ifid,
                   cif.flush_idex, cif.flush_exmem,
                   cif.flush_memwb}),
             int'({me.pc, me.en, me.fl}));
         chk("halt", int'(cif.halt), int'(me.hlt));
         chk("mem_timeout", int'(cif.mem_timeout), int'(me.tmo));
         chk("stall_cnt", int'(cif.stall_cnt), int'(me.sc));
         chk("flush_cnt", int'(cif.flush_cnt), int'(me.fc));
      end
   end

   initial begin
      in_t v;
      RST = 1'b1;
      cif.ihit = 0; cif.dhit = 0; cif.mem_dREN = 0;
      cif.mem_dWEN = 0; cif.mem_branch_taken = 0;
      cif.mem_halt = 0; cif.ex_jump = 0; cif.idex_dREN = 0;
      cif.idex_rt = 0; cif.ifid_rs = 0; cif.ifid_rt = 0;

      // reset then idle
      step(rsti());
      @(negedge CLK);
      chk("rst_flushes", int'({cif.flush_ifid, cif.flush_idex,
          cif.flush_exmem, cif.flush_memwb}), 15);
      chk("rst_pc_en", int'(cif.pc_en), 0);
      step(idle());
      @(negedge CLK);
      chk("idle_en", int'({cif.pc_en, cif.en_ifid, cif.en_idex,
          cif.en_exmem, cif.en_memwb}), 31);

      // load-use on rs
      v = idle(); v.ldr = 1; v.irt = 8; v.rs = 8; v.rt = 3;
      step(v);
      @(negedge CLK);
      chk("lu_pc_en", int'(cif.pc_en), 0);
      chk("lu_flush_idex", int'(cif.flush_idex), 1);
      step(idle());
      @(negedge CLK);
      chk("lu_stall_cnt", int'(cif.stall_cnt), 1);

      // load into r0 never stalls
      v = idle(); v.ldr = 1; v.irt = 0; v.rs = 0; v.rt = 0;
      step(v);
      @(negedge CLK);
      chk("lu_r0_pc_en", int'(cif.pc_en), 1);

      // branch beats load-use
      v = idle(); v.ldr = 1; v.irt = 9; v.rt = 9; v.br = 1;
      step(v);
      @(negedge CLK);
      chk("br_flushes", int'({cif.pc_en, cif.flush_ifid,
          cif.flush_idex, cif.flush_exmem}), 15);
      step(idle());
      @(negedge CLK);
      chk("br_flush_cnt", int'(cif.flush_cnt), 2);

      // memory wait, 3 stalled cycles
      step(rsti());
      step(idle());
      v = idle(); v.dren = 1;
      repeat (3) step(v);
      @(negedge CLK);
      chk("mw_en", int'({cif.pc_en, cif.en_ifid, cif.en_idex,
          cif.en_exmem, cif.en_memwb, cif.flush_memwb}), 3);
      v.dhit = 1;
      step(v);
      step(idle());
      @(negedge CLK);
      chk("mw_stall_cnt", int'(cif.stall_cnt), 3);

      // timeout after 4 DWAIT cycles, sticky until reset
      step(rsti());
      step(idle());
      v = idle(); v.dwen = 1;
      repeat (4) step(v);
      @(negedge CLK);
      chk("tmo_early", int'(cif.mem_timeout), 0);
      step(v);
      v.dhit = 1;
      step(v);
      @(negedge CLK);
      chk("tmo_set", int'(cif.mem_timeout), 1);
      step(idle());
      @(negedge CLK);
      chk("tmo_sticky", int'(cif.mem_timeout), 1);
      step(rsti());
      step(idle());
      @(negedge CLK);
      chk("tmo_cleared", int'(cif.mem_timeout), 0);

      // halt drain
      v = idle(); v.mh = 1;
      step(v);
      step(idle());
      @(negedge CLK);
      chk("drain_en_memwb", int'({cif.pc_en, cif.en_memwb}), 1);
      step(idle());
      @(negedge CLK);
      chk("halted", int'({cif.halt, cif.pc_en}), 2);
      step(rsti());
      step(idle());
      v = idle(); v.mh = 1;
      step(v);
      step(rsti());
      step(idle());
      @(negedge CLK);
      chk("rst_in_drain", int'({cif.halt, cif.pc_en}), 1);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         if ((mode == 3 && $urandom_range(3) == 0) ||
             $urandom_range(299) == 0) begin
            step(rsti());
         end else begin
            v      = '0;
            v.ihit = ($urandom_range(7) != 0);
            if ($urandom_range(4) == 0) begin
               if ($urandom_range(1) == 0) v.dren = 1;
               else v.dwen = 1;
            end
            v.dhit = $urandom_range(1) == 1;
            v.br   = ($urandom_range(9) == 0);
            v.jmp  = ($urandom_range(9) == 0);
            v.mh   = ($urandom_range(39) == 0);
            v.ldr  = ($urandom_range(2) == 0);
            v.irt  = 5'($urandom_range(3));
            v.rs   = 5'($urandom_range(3));
            v.rt   = 5'($urandom_range(3));
            step(v);
         end
      end

      @(posedge CLK);
      @(negedge CLK);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
